// File: rtl/cpu_req_gen.sv
// Directed CPU-side request generator: walks a built-in request program against a
// cache port, tallies hits/misses/read mismatches, and aborts on a ready timeout.
`timescale 1ns/1ps
module cpu_req_gen #(
  parameter int N_OPS   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cpu_req,
  output logic        cpu_we,
  output logic [15:0] cpu_addr,
  output logic [31:0] cpu_wdata,
  input  logic        cpu_ready,
  input  logic        cpu_hit,
  input  logic [31:0] cpu_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt,
  output logic [7:0]  mism_cnt
);

  localparam int IW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic        we;
    logic        chk;
    logic [15:0] addr;
    logic [31:0] data;
  } op_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERR} state_t;

  // data doubles as write data (we=1) or expected read data (chk=1)
  function automatic op_t rom(input logic [IW-1:0] i);
    case (int'(i))
      0:       rom = {1'b0, 1'b0, 16'h1000, 32'h0000_0000};
      1:       rom = {1'b0, 1'b0, 16'h1000, 32'h0000_0000};
      2:       rom = {1'b0, 1'b0, 16'h1800, 32'h0000_0000};
      3:       rom = {1'b0, 1'b0, 16'h1000, 32'h0000_0000};
      4:       rom = {1'b0, 1'b0, 16'h1000, 32'h0000_0000};
      5:       rom = {1'b1, 1'b0, 16'h1004, 32'hDEAD_BEEF};
      6:       rom = {1'b0, 1'b1, 16'h1004, 32'hDEAD_BEEF};
      7:       rom = {1'b1, 1'b0, 16'h2000, 32'hAAAA_AAAA};
      8:       rom = {1'b0, 1'b1, 16'h2000, 32'hAAAA_AAAA};
      default: rom = '0;
    endcase
  endfunction

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic          accept, complete, last;
  op_t           cur, load_op;

  assign cur     = rom(idx);
  assign load_op = rom(accept ? '0 : idx);
  assign last    = (idx == IW'(N_OPS - 1));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) begin
        state_nx = ISSUE;
        accept   = 1'b1;
      end
      ISSUE: state_nx = WAIT;
      // ready wins over a timeout landing in the same cycle
      WAIT: if (cpu_ready) begin
        complete = 1'b1;
        state_nx = last ? DONE : GAP;
      end else if (timer == TW'(TIMEOUT - 1)) begin
        state_nx = ERR;
      end
      GAP:     state_nx = ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered off state_nx so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      timer     <= '0;
      cpu_req   <= 1'b0;
      cpu_we    <= 1'b0;
      cpu_addr  <= 16'h0000;
      cpu_wdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      hit_cnt   <= 8'h00;
      miss_cnt  <= 8'h00;
      mism_cnt  <= 8'h00;
    end else begin
      state   <= state_nx;
      cpu_req <= (state_nx == ISSUE);
      busy    <= (state_nx inside {ISSUE, WAIT, GAP});
      done    <= (state_nx == DONE);
      err     <= (state_nx == ERR);
      if (state_nx == ISSUE) begin
        cpu_we    <= load_op.we;
        cpu_addr  <= load_op.addr;
        cpu_wdata <= load_op.data;
      end
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT && !cpu_ready)
        timer <= timer + TW'(1);
      if (accept) begin
        idx      <= '0;
        hit_cnt  <= 8'h00;
        miss_cnt <= 8'h00;
        mism_cnt <= 8'h00;
      end
      if (complete) begin
        if (cpu_hit) begin
          if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
        end else begin
          if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
        end
        if (!cur.we && cur.chk && cpu_rdata != cur.data && mism_cnt != 8'hFF)
          mism_cnt <= mism_cnt + 8'd1;
        if (!last) idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: doc/cpu_req_gen.md
CPU_REQ_GEN -- requirements
Module: cpu_req_gen

Interface
REQ-001 Parameter N_OPS, default 9: number of entries in the built-in request program.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for cpu_ready per request.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that launches the program.
REQ-006 cpu_req  output  1  request strobe to the cache.
REQ-007 cpu_we  output  1  1 = write, 0 = read.
REQ-008 cpu_addr  output  16  byte address.
REQ-009 cpu_wdata  output  32  write data.
REQ-010 cpu_ready  input  1  cache completion pulse.
REQ-011 cpu_hit  input  1  hit flag, valid while cpu_ready = 1.
REQ-012 cpu_rdata  input  32  read data, valid while cpu_ready = 1.
REQ-013 busy  output  1  program running.
REQ-014 done  output  1  program completed.
REQ-015 err  output  1  timeout abort.
REQ-016 hit_cnt, miss_cnt, mism_cnt  output  8 each  hit, miss and read-data mismatch counts.

Function
REQ-017 Program SHALL be an internal ROM of N_OPS entries {we, chk, addr[15:0], data[31:0]}; data is wdata for writes and expected rdata for reads with chk = 1.
REQ-018 Default program, in order: R 1000; R 1000; R 1800; R 1000; R 1000; W 1004 = DEADBEEF; R 1004 chk DEADBEEF; W 2000 = AAAAAAAA; R 2000 chk AAAAAAAA.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, GAP, DONE, ERR.
REQ-020 IDLE/DONE/ERR + start: clear idx, all counters, done and err; go to ISSUE next cycle.
REQ-021 start SHALL be ignored in ISSUE, WAIT and GAP.
REQ-022 ISSUE: cpu_req = 1 for exactly one cycle; cpu_we, cpu_addr, cpu_wdata come from ROM[idx]; next state is WAIT with timer = 0.
REQ-023 cpu_we, cpu_addr and cpu_wdata SHALL stay stable from ISSUE until the cycle cpu_ready is sampled high.
REQ-024 WAIT: cpu_ready SHALL be sampled only in WAIT, which begins the cycle after the cpu_req pulse.
REQ-025 WAIT with cpu_ready = 1: increment hit_cnt if cpu_hit, else miss_cnt; if read with chk = 1 and cpu_rdata != data, increment mism_cnt.
REQ-026 After a completed request: if idx == N_OPS-1, go to DONE; else idx+1 and go to GAP.
REQ-027 GAP SHALL last one cycle with cpu_req = 0, then go to ISSUE.
REQ-028 WAIT: timer increments each cycle without cpu_ready; timer reaching TIMEOUT goes to ERR; cpu_ready in that same cycle still completes normally (ready has priority).
REQ-029 All counters SHALL saturate at 8'hFF.
REQ-030 busy = 1 in ISSUE, WAIT and GAP only.
REQ-031 done = 1 held in DONE; err = 1 held in ERR; both hold until the next accepted start.
REQ-032 cpu_req SHALL never be asserted outside ISSUE.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst low SHALL asynchronously force IDLE and clear idx, timer, all counters and every output; this includes cpu_addr = 16'h0000 and cpu_wdata = 32'h0.
REQ-035 rst asserted mid-request SHALL abort the request immediately with no further cpu_req; operation resumes only on a start after rst is released.

Verification
REQ-036 Default program against a bench responder giving cpu_ready 3 cycles after cpu_req, hits on ops 2, 5, 6, 7, and rdata equal to expected -> done = 1, hit_cnt = 4, miss_cnt = 5, mism_cnt = 0, exactly 9 cpu_req pulses each separated by at least 2 low cycles.
REQ-037 Same run with op 7 returning 12345678 -> mism_cnt = 1, done = 1.
REQ-038 Responder never raises cpu_ready on op 1 -> err = 1 after 255 WAIT cycles, busy = 0, exactly one cpu_req pulse.
REQ-039 start pulsed during WAIT -> ignored, program and counters unaffected; start in DONE -> counters cleared and program reruns.
REQ-040 rst driven low during op 4 WAIT -> all outputs 0 asynchronously; the next start reruns from op 1 with counters at 0.
REQ-041 cpu_ready returned in the same cycle the timer reaches TIMEOUT -> request completes, no err.
